adder_fu_pipe: RTL

//  Next-generation CGRA tile adder FU: LANES x WIDTH-bit lanes, fusible at run time into groups of 2^k lanes.
//  Per-transaction add/sub with optional unsigned saturation. 2-stage carry-select pipeline with valid/ready on both sides.

---
 rtl/adder_fu_pipe.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/adder_fu_pipe.sv
// adder_fu_pipe: LANES x WIDTH-bit adder functional unit whose lanes can be fused
// at run time into groups of 2^k lanes. Each beat is an add or a subtract, with
// optional unsigned saturation per group.
//
// The pipeline has two stages with valid/ready on both sides. Stage 1 registers
// the per-lane carry-select pair: one sum assuming carry-in 0 and one assuming
// carry-in 1. Stage 2 ripples the group carry across the lanes and picks each
// lane's sum, saturates it if needed, and registers the result.
module adder_fu_pipe #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int CFG_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,      // asynchronous, active-low
  input  logic                   on_off,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CFG_W-1:0]       config_in,
  input  logic                   op_in,
  input  logic                   sat_en,
  input  logic [LANES*WIDTH-1:0] a_in,
  input  logic [LANES*WIDTH-1:0] b_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       carry_out,
  output logic                   busy
);

  localparam int LOG_L = (LANES > 1) ? $clog2(LANES) : 0;

  // Stage 1 state.
  logic                        s1_valid;
  logic [CFG_W-1:0]            s1_k;
  logic                        s1_op;
  logic                        s1_sat;
  logic [LANES-1:0][WIDTH-1:0] s1_sum0;
  logic [LANES-1:0][WIDTH-1:0] s1_sum1;
  logic [LANES-1:0]            s1_c0;
  logic [LANES-1:0]            s1_c1;

  // Stage 2 state. The result and carry_out registers are the outputs.
  logic                        s2_valid;

  // Combinational next-state values.
  logic [LANES-1:0][WIDTH-1:0] nx_sum0;
  logic [LANES-1:0][WIDTH-1:0] nx_sum1;
  logic [LANES-1:0]            nx_c0;
  logic [LANES-1:0]            nx_c1;
  logic [LANES*WIDTH-1:0]      nx_result;
  logic [LANES-1:0]            nx_carry;

  logic accept;
  logic s2_load;

  // Accept when stage 1 is empty, or when it is about to move into stage 2.
  assign in_ready  = on_off & (!s1_valid | !s2_valid | out_ready);
  assign accept    = in_valid & in_ready;
  // Stage 1 moves into stage 2 when stage 2 is empty or is retiring this cycle.
  assign s2_load   = s1_valid & (!s2_valid | out_ready);
  assign out_valid = s2_valid;
  assign busy      = s1_valid | s2_valid;

  // Stage 1 datapath: invert B for subtract and form both carry-select sums per lane.
  always_comb begin
    logic [WIDTH-1:0] bp;
    logic [WIDTH:0]   t0;
    logic [WIDTH:0]   t1;
    // NOTE: every variable gets a default before any branch, so no latches are inferred.
    bp      = '0;
    t0      = '0;
    t1      = '0;
    nx_sum0 = '0;
    nx_sum1 = '0;
    nx_c0   = '0;
    nx_c1   = '0;
    for (int i = 0; i < LANES; i++) begin
      bp = op_in ? ~b_in[i*WIDTH +: WIDTH] : b_in[i*WIDTH +: WIDTH];
      t0 = {1'b0, a_in[i*WIDTH +: WIDTH]} + {1'b0, bp};
      t1 = {1'b0, a_in[i*WIDTH +: WIDTH]} + {1'b0, bp} + (WIDTH+1)'(1);
      nx_sum0[i] = t0[WIDTH-1:0];
      nx_c0[i]   = t0[WIDTH];
      nx_sum1[i] = t1[WIDTH-1:0];
      nx_c1[i]   = t1[WIDTH];
    end
  end

  // Stage 2 datapath: ripple the carry through each group, select sums, then saturate.
  always_comb begin
    int               grp_log;
    int               gmask;
    logic             cin;
    logic             g;
    logic [LANES-1:0] csel;
    grp_log   = (int'(s1_k) > LOG_L) ? LOG_L : int'(s1_k);
    gmask     = (1 << grp_log) - 1;
    cin       = 1'b0;
    g         = 1'b0;
    csel      = '0;
    nx_result = '0;
    nx_carry  = '0;
    // Walk upwards: the lowest lane of each group takes op as its carry-in.
    for (int j = 0; j < LANES; j++) begin
      if ((j & gmask) == 0) cin = s1_op;
      csel[j] = cin ? s1_c1[j] : s1_c0[j];
      nx_result[j*WIDTH +: WIDTH] = cin ? s1_sum1[j] : s1_sum0[j];
      if ((j & gmask) == gmask) nx_carry[j] = csel[j];
      cin = csel[j];
    end
    // Walk downwards: carry the group carry from the top lane to every lane of the group.
    for (int j = LANES - 1; j >= 0; j--) begin
      if ((j & gmask) == gmask) g = csel[j];
      if (s1_sat && (s1_op ? !g : g))
        nx_result[j*WIDTH +: WIDTH] = s1_op ? '0 : '1;
    end
  end

  // Valid bits for both stages. Reset discards any beats in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept | (s1_valid & !s2_load);
      s2_valid <= s2_load | (s2_valid & !out_ready);
    end
  end

  // Stage 1 payload register, loaded on every accepted beat.
  // NOTE: the payload has no reset; s1_valid qualifies it, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_k    <= config_in;
      s1_op   <= op_in;
      s1_sat  <= sat_en;
      s1_sum0 <= nx_sum0;
      s1_sum1 <= nx_sum1;
      s1_c0   <= nx_c0;
      s1_c1   <= nx_c1;
    end
  end

  // Stage 2 output registers. They hold their value while a stalled beat waits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result    <= '0;
      carry_out <= '0;
    end else if (s2_load) begin
      result    <= nx_result;
      carry_out <= nx_carry;
    end
  end

endmodule
